// File: rtl/mxn_pkg.sv
// Shared definitions for the mux family: mode encodings, default sizes and
// a select-width helper.
package mxn_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_NCH   = 8;

    // Pointer width able to address n channels (at least one bit).
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEFAULT_SELW = sel_width(DEFAULT_NCH);

endpackage

// File: rtl/mxn_tree.sv
// Combinational NCH:1 selector built as a log2-depth tree of 2:1 stages.
// Leaves beyond NCH are tied to zero, so an out-of-range select yields 0.
module mxn_tree
    import mxn_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned SELW  = DEFAULT_SELW
) (
    input  logic [NCH*WIDTH-1:0] d_i,
    input  logic [SELW-1:0]      sel_i,
    output logic [WIDTH-1:0]     y_o
);

    localparam int unsigned LEAVES = 2**SELW;

    // Heap-ordered nodes: root at 1, children of n at 2n and 2n+1, leaves at LEAVES+k.
    logic [WIDTH-1:0] node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < NCH) begin : g_chan
            assign node[LEAVES+i] = d_i[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign node[LEAVES+i] = '0;
        end
    end

    // Level l decides on select bit SELW-1-l, so the root consumes the MSB.
    for (genvar l = 0; l < SELW; l++) begin : g_lvl
        for (genvar j = 0; j < (2**l); j++) begin : g_node
            assign node[(2**l)+j] = sel_i[SELW-1-l] ? node[2*((2**l)+j)+1]
                                                    : node[2*((2**l)+j)];
        end
    end

    assign y_o = node[1];

endmodule

// File: rtl/mxn_pipe.sv
// Registered channel selector with valid/ready handshake, supporting direct
// select or an auto-incrementing scan pointer.
module mxn_pipe
    import mxn_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned NCH   = DEFAULT_NCH,
    parameter int unsigned SELW  = DEFAULT_SELW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NCH*WIDTH-1:0] d,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 scan_clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     y,
    output logic [SELW-1:0]      y_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

    logic [WIDTH-1:0] y_q,        y_d;
    logic [SELW-1:0]  y_ch_q,     y_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  scan_ptr_q, scan_ptr_d;

    logic             accept_c;
    logic [SELW-1:0]  ch_c;
    logic [WIDTH-1:0] tree_y_c;

    assign in_ready = !out_valid_q || out_ready;
    assign accept_c = in_valid && in_ready;
    assign ch_c     = (mode_e'(mode) == MODE_SCAN) ? scan_ptr_q : sel;

    mxn_tree #(
        .WIDTH (WIDTH),
        .NCH   (NCH),
        .SELW  (SELW)
    ) u_tree (
        .d_i   (d),
        .sel_i (ch_c),
        .y_o   (tree_y_c)
    );

    // Output stage: load on accept, drop valid on a consume-only edge.
    always_comb begin
        y_d         = y_q;
        y_ch_d      = y_ch_q;
        out_valid_d = out_valid_q;
        if (accept_c) begin
            y_d         = tree_y_c;
            y_ch_d      = ch_c;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Scan pointer: clear has priority over the post-accept increment.
    always_comb begin
        scan_ptr_d = scan_ptr_q;
        if (scan_clr) begin
            scan_ptr_d = '0;
        end else if (accept_c && (mode_e'(mode) == MODE_SCAN)) begin
            scan_ptr_d = (scan_ptr_q == LAST_CH) ? '0 : scan_ptr_q + SELW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q         <= '0;
            y_ch_q      <= '0;
            out_valid_q <= 1'b0;
            scan_ptr_q  <= '0;
        end else begin
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            out_valid_q <= out_valid_d;
            scan_ptr_q  <= scan_ptr_d;
        end
    end

    assign y         = y_q;
    assign y_ch      = y_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mxn_pipe.sv
// Bench for mxn_pipe: an 8-channel and a 5-channel instance driven in
// parallel and compared with a behavioural model plus directed vectors.
module tb_mxn_pipe;
    import mxn_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic [8*W-1:0] d8;
    logic [5*W-1:0] d5;
    logic [2:0]     sel;
    logic           mode, scan_clr, in_valid, out_ready;
    logic           rdy8, v8, rdy5, v5;
    logic [W-1:0]   y8, y5;
    logic [2:0]     ch8, ch5;

    always #5 clk = ~clk;

    mxn_pipe #(.WIDTH(W), .NCH(8), .SELW(3)) dut (
        .clk(clk), .reset(reset), .d(d8), .sel(sel), .mode(mode),
        .scan_clr(scan_clr), .in_valid(in_valid), .in_ready(rdy8),
        .y(y8), .y_ch(ch8), .out_valid(v8), .out_ready(out_ready)
    );

    mxn_pipe #(.WIDTH(W), .NCH(5), .SELW(3)) dut5 (
        .clk(clk), .reset(reset), .d(d5), .sel(sel), .mode(mode),
        .scan_clr(scan_clr), .in_valid(in_valid), .in_ready(rdy5),
        .y(y5), .y_ch(ch5), .out_valid(v5), .out_ready(out_ready)
    );

    logic [31:0] chan8 [8];
    logic [31:0] chan5 [5];
    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state per instance (0 = 8 channels, 1 = 5 channels).
    logic [31:0] m_y   [2];
    int          m_ch  [2];
    bit          m_v   [2];
    int          m_ptr [2];

    typedef struct {
        logic [2:0]  sel;
        logic        mode;
        logic        iv;
        logic        orr;
        logic        clr;
        logic        exp_rdy;
        logic [31:0] exp_y;
        logic [2:0]  exp_ch;
        logic        exp_v;
    } vec_t;

    vec_t tbl [9];

    function automatic int nch_of(input int u);
        return (u == 0) ? 8 : 5;
    endfunction

    function automatic logic [31:0] chan_of(input int u, input int k);
        if (k >= nch_of(u)) return 32'h0;
        return (u == 0) ? chan8[k] : chan5[k];
    endfunction

    task automatic pack_data();
        for (int k = 0; k < 8; k++) d8[k*W +: W] = chan8[k];
        for (int k = 0; k < 5; k++) d5[k*W +: W] = chan5[k];
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_y[u] = 32'h0; m_ch[u] = 0; m_v[u] = 1'b0; m_ptr[u] = 0;
        end
    endtask

    task automatic model_edge();
        for (int u = 0; u < 2; u++) begin
            bit rdy, acc;
            int ch;
            rdy = !m_v[u] || out_ready;
            acc = in_valid && rdy;
            ch  = mode ? m_ptr[u] : int'(sel);
            if (acc) begin
                m_y[u] = chan_of(u, ch); m_ch[u] = ch; m_v[u] = 1'b1;
            end else if (out_ready) begin
                m_v[u] = 1'b0;
            end
            if (scan_clr) m_ptr[u] = 0;
            else if (acc && mode) m_ptr[u] = (m_ptr[u] + 1) % nch_of(u);
        end
    endtask

    task automatic check_model();
        chk("y8",     y8,         m_y[0]);
        chk("ch8",    32'(ch8),   32'(m_ch[0]));
        chk("v8",     32'(v8),    32'(m_v[0]));
        chk("y5",     y5,         m_y[1]);
        chk("ch5",    32'(ch5),   32'(m_ch[1]));
        chk("v5",     32'(v5),    32'(m_v[1]));
    endtask

    task automatic drive(input logic [2:0] s, input logic m, input logic iv,
                         input logic orr, input logic clr);
        sel = s; mode = m; in_valid = iv; out_ready = orr; scan_clr = clr;
    endtask

    // One clock: check ready before the edge, model the edge, check outputs after.
    task automatic cycle();
        #1;
        chk("rdy8", 32'(rdy8), 32'(!m_v[0] || out_ready));
        chk("rdy5", 32'(rdy5), 32'(!m_v[1] || out_ready));
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_y",   y8,         32'h0);
        chk("rst_ch",  32'(ch8),   32'h0);
        chk("rst_v",   32'(v8),    32'h0);
        chk("rst_rdy", 32'(rdy8),  32'h1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) chan8[k] = 32'h1000_0000 + 32'(k);
        for (int k = 0; k < 5; k++) chan5[k] = 32'h2000_0000 + 32'(k);
        pack_data();
        model_reset();

        //          sel   mode  iv    or    clr   rdy   y              ch    v
        tbl[0] = '{3'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0005, 3'd5, 1'b1};
        tbl[1] = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000_0005, 3'd5, 1'b1};
        tbl[2] = '{3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0003, 3'd3, 1'b1};
        tbl[3] = '{3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0003, 3'd3, 1'b0};
        tbl[4] = '{3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1000_0000, 3'd0, 1'b1};
        tbl[5] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 3'd0, 1'b1};
        tbl[6] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 3'd1, 1'b1};
        tbl[7] = '{3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 3'd2, 1'b1};
        tbl[8] = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 3'd2, 1'b1};

        do_reset();

        // Directed table from reset, first accept on the first edge after release.
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].sel, tbl[i].mode, tbl[i].iv, tbl[i].orr, tbl[i].clr);
            #1;
            chk($sformatf("tbl%0d_rdy", i), 32'(rdy8), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            model_edge();
            #1;
            chk($sformatf("tbl%0d_y", i),  y8,        tbl[i].exp_y);
            chk($sformatf("tbl%0d_ch", i), 32'(ch8),  32'(tbl[i].exp_ch));
            chk($sformatf("tbl%0d_v", i),  32'(v8),   32'(tbl[i].exp_v));
            check_model();
        end

        // Scan mode: ten back-to-back accepts wrap 0..7,0,1 with no bubbles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle();
            chk($sformatf("scan%0d_ch", i), 32'(ch8), 32'(i % 8));
            chk($sformatf("scan%0d_y", i),  y8,       32'h1000_0000 + 32'(i % 8));
            chk($sformatf("scan%0d_v", i),  32'(v8),  32'h1);
        end

        // Backpressure holds channel 2, then the pointer has advanced only once.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        for (int i = 0; i < 5; i++) begin
            drive(3'd5, 1'b1, 1'b1, 1'b0, 1'b0);
            cycle();
            chk("bp_rdy", 32'(rdy8), 32'h0);
            chk("bp_ch",  32'(ch8),  32'h2);
            chk("bp_y",   y8,        32'h1000_0002);
        end
        drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("bp_next_ch", 32'(ch8), 32'h3);

        // Clear coinciding with an accept: sample uses old pointer, then restarts.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
            cycle();
        end
        drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        chk("clr_ch", 32'(ch8), 32'h6);
        drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("clr_next_ch", 32'(ch8), 32'h0);

        // Out-of-range select on the 5-channel instance.
        drive(3'd7, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("oor_y",  y5,        32'h0);
        chk("oor_ch", 32'(ch5),  32'h7);
        chk("oor_v",  32'(v5),   32'h1);
        chk("oor_y8", y8,        32'h1000_0007);

        // Asynchronous reset pulse between edges while a sample is held.
        drive(3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("ar_pre_v", 32'(v8), 32'h1);
        drive(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("ar_y",   y8,        32'h0);
        chk("ar_ch",  32'(ch8),  32'h0);
        chk("ar_v",   32'(v8),   32'h0);
        chk("ar_rdy", 32'(rdy8), 32'h1);
        #1;
        reset = 1'b0;
        model_reset();
        drive(3'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle();
        chk("ar_scan0", 32'(ch8), 32'h0);
        cycle();
        chk("ar_scan1", 32'(ch8), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 8; k++) chan8[k] = $urandom;
            for (int k = 0; k < 5; k++) chan5[k] = $urandom;
            pack_data();
            drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
